// File: rtl/rsa_uart_ctrl.sv
// rtl/rsa_uart_ctrl.sv - framed command parser and start/done sequencer for the RSA core
// Assembles LSB-first operands from the UART byte stream and commits them atomically.
module rsa_uart_ctrl #(
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CLKS = 3480
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Rx_Valid,
  input  logic              i_Done,
  output logic [DATA_W-1:0] o_Cipher,
  output logic [DATA_W-1:0] o_Exp,
  output logic [DATA_W-1:0] o_Mod,
  output logic [2:0]        o_Loaded,
  output logic              o_Start,
  output logic              o_Busy,
  output logic              o_Err
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_START, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] cipher_q, cipher_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [2:0]        loaded_q, loaded_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] word_c;
  logic              in_frame_c;
  logic              timed_out_c;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    cipher_d   = cipher_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    loaded_d   = loaded_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    word_c     = shadow_q;
    word_c[DATA_W-8 +: 8] = i_Rx_Byte;
    in_frame_c = (state_q == S_CMD) || (state_q == S_DATA);
    // The timeout wins over a byte arriving on the same edge.
    timed_out_c = in_frame_c && (timer_q == TW'(TIMEOUT_CLKS - 1));
    timer_d    = (in_frame_c && !i_Rx_Valid) ? timer_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_Valid && i_Rx_Byte == 8'hA5) begin
          state_d = S_CMD;
          err_d   = 1'b0;
        end
      end
      S_CMD: begin
        if (timed_out_c) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (i_Rx_Valid) begin
          case (i_Rx_Byte)
            8'h01, 8'h02, 8'h03: begin
              tgt_d   = i_Rx_Byte[1:0];
              cnt_d   = '0;
              state_d = S_DATA;
            end
            8'h10: begin
              if (loaded_q == 3'b111) begin
                state_d = S_START;
                start_d = 1'b1;
                busy_d  = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
      end
      S_DATA: begin
        if (timed_out_c) begin
          err_d    = 1'b1;
          shadow_d = '0;
          state_d  = S_IDLE;
        end else if (i_Rx_Valid) begin
          if (cnt_q == CW'(NB - 1)) begin
            case (tgt_q)
              2'd1:    cipher_d = word_c;
              2'd2:    exp_d    = word_c;
              default: mod_d    = word_c;
            endcase
            loaded_d[tgt_q - 2'd1] = 1'b1;
            state_d = S_IDLE;
          end else begin
            shadow_d[8*cnt_q +: 8] = i_Rx_Byte;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        if (i_Rx_Valid) err_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_Rx_Valid) err_d = 1'b1;
        if (i_Done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      cipher_q <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      loaded_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      cipher_q <= cipher_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      loaded_q <= loaded_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign o_Cipher = cipher_q;
  assign o_Exp    = exp_q;
  assign o_Mod    = mod_q;
  assign o_Loaded = loaded_q;
  assign o_Start  = start_q;
  assign o_Busy   = busy_q;
  assign o_Err    = err_q;

endmodule

// File: tb/tb_rsa_uart_ctrl.sv
// tb/tb_rsa_uart_ctrl.sv - directed and randomized frame checks against a byte-level reference model
module tb_rsa_uart_ctrl;
  localparam int DW = 32;
  localparam int TO = 3480;
  localparam int NB = DW / 8;

  logic          i_Clock = 1'b0;
  logic          i_Reset;
  logic [7:0]    i_Rx_Byte;
  logic          i_Rx_Valid;
  logic          i_Done;
  logic [DW-1:0] o_Cipher, o_Exp, o_Mod;
  logic [2:0]    o_Loaded;
  logic          o_Start, o_Busy, o_Err;

  rsa_uart_ctrl #(.DATA_W(DW), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_Byte(i_Rx_Byte),
    .i_Rx_Valid(i_Rx_Valid), .i_Done(i_Done), .o_Cipher(o_Cipher),
    .o_Exp(o_Exp), .o_Mod(o_Mod), .o_Loaded(o_Loaded), .o_Start(o_Start),
    .o_Busy(o_Busy), .o_Err(o_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 0 idle, 1 awaiting command, 2 collecting payload, 3 start cycle, 4 core busy
  int                m_phase;
  int                m_tgt;
  int                m_idle;
  bit [31:0]         m_reg [1:3];
  bit [2:0]          m_loaded;
  bit                m_err;
  byte unsigned      m_pay [$];

  function automatic void model_reset();
    m_phase = 0; m_tgt = 1; m_idle = 0; m_loaded = 3'b000; m_err = 1'b0;
    m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
    m_pay.delete();
  endfunction

  function automatic void model_edge(input bit v, input byte unsigned b, input bit d);
    case (m_phase)
      0: if (v && b == 8'hA5) begin m_phase = 1; m_err = 1'b0; m_idle = 0; end
      1, 2: begin
        if (m_idle == TO - 1) begin
          m_err = 1'b1; m_phase = 0; m_pay.delete();
        end else if (!v) begin
          m_idle++;
        end else begin
          m_idle = 0;
          if (m_phase == 1) begin
            if (b >= 1 && b <= 3) begin m_tgt = b; m_pay.delete(); m_phase = 2; end
            else if (b == 8'h10 && m_loaded == 3'b111) m_phase = 3;
            else begin m_err = 1'b1; m_phase = 0; end
          end else begin
            m_pay.push_back(b);
            if (m_pay.size() == NB) begin
              m_reg[m_tgt] = {m_pay[3], m_pay[2], m_pay[1], m_pay[0]};
              m_loaded[m_tgt-1] = 1'b1;
              m_phase = 0;
            end
          end
        end
      end
      3: begin if (v) m_err = 1'b1; m_phase = 4; end
      default: begin if (v) m_err = 1'b1; if (d) m_phase = 0; end
    endcase
  endfunction

  task automatic compare_all();
    check("start",  o_Start,  (m_phase == 3));
    check("busy",   o_Busy,   (m_phase == 3 || m_phase == 4));
    check("err",    o_Err,    m_err);
    check("loaded", o_Loaded, m_loaded);
    check("cipher", o_Cipher, m_reg[1]);
    check("exp",    o_Exp,    m_reg[2]);
    check("mod",    o_Mod,    m_reg[3]);
  endtask

  task automatic step(input bit v, input byte unsigned b, input bit d);
    i_Rx_Valid = v; i_Rx_Byte = b; i_Done = d;
    @(posedge i_Clock); #1;
    i_Rx_Valid = 1'b0; i_Done = 1'b0;
    model_edge(v, b, d);
    compare_all();
  endtask

  task automatic send(input byte unsigned b, input int gap);
    step(1'b1, b, 1'b0);
    repeat (gap) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic load(input byte unsigned cmd, input bit [31:0] val, input int gap);
    send(8'hA5, gap);
    send(cmd, gap);
    for (int i = 0; i < NB; i++) send(val[8*i +: 8], gap);
  endtask

  task automatic pulse_reset();
    #2 i_Reset = 1'b1;
    #1;
    check("rst_cipher", o_Cipher, 32'h0);
    check("rst_loaded", o_Loaded, 32'h0);
    check("rst_busy",   o_Busy,   32'h0);
    check("rst_err",    o_Err,    32'h0);
    @(posedge i_Clock); #1 i_Reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    i_Reset = 1'b1; i_Rx_Valid = 1'b0; i_Rx_Byte = 8'h00; i_Done = 1'b0;
    model_reset();
    repeat (2) @(posedge i_Clock);
    #1 i_Reset = 1'b0;
    compare_all();

    send(8'hA5, 0); send(8'h02, 1); send(8'h11, 0);
    pulse_reset();
    load(8'h01, 32'hDEADBEEF, 0);
    check("cipher_deadbeef", o_Cipher, 32'hDEADBEEF);
    check("loaded_001", o_Loaded, 32'h1);

    send(8'hA5, 0); send(8'h10, 3);
    check("premature_err", o_Err, 32'h1);
    send(8'hA5, 0);
    check("err_cleared", o_Err, 32'h0);
    send(8'h7F, 0);
    check("bad_cmd_err", o_Err, 32'h1);

    load(8'h02, 32'h0000_0007, 1);
    send(8'h00, 0); send(8'hFF, 0);
    check("stray_no_err", o_Err, 32'h0);
    load(8'h01, 32'h0000_0BB8, 0);
    load(8'h03, 32'h0000_0D0F, 870);
    check("uart_paced_mod", o_Mod, 32'h0000_0D0F);

    send(8'hA5, 0); send(8'h10, 0);
    step(1'b0, 8'h00, 1'b1);
    check("done_in_start_ignored", o_Busy, 32'h1);
    send(8'hA5, 0); send(8'h01, 0); send(8'h11, 0);
    send(8'h22, 0); send(8'h33, 0); send(8'h44, 2);
    check("overrun_err", o_Err, 32'h1);
    check("overrun_cipher", o_Cipher, 32'h0000_0BB8);
    step(1'b1, 8'h55, 1'b1);
    check("busy_after_done", o_Busy, 32'h0);

    send(8'hA5, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
    repeat (TO) step(1'b0, 8'h00, 1'b0);
    check("timeout_err", o_Err, 32'h1);
    check("timeout_exp", o_Exp, 32'h7);
    load(8'h02, 32'h0000_0001, 0);
    check("exp_reload", o_Exp, 32'h1);

    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      r = $urandom_range(0, 5);
      if (r <= 2) begin
        load(8'($urandom_range(1, 3)), $urandom, $urandom_range(0, 3));
      end else if (r == 3) begin
        send(8'hA5, 0); send(8'h10, 0);
        repeat ($urandom_range(0, 6)) step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
        step($urandom_range(0, 1), 8'($urandom), 1'b1);
      end else if (r == 4) begin
        byte unsigned s;
        s = 8'($urandom);
        if (s == 8'hA5) s = 8'h00;
        step(1'b1, s, $urandom_range(0, 1));
      end else begin
        send(8'hA5, $urandom_range(0, 2));
        send(8'($urandom_range(4, 255)), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_uart_ctrl.md
# rsa_uart_ctrl

Command/frame controller between the UART receiver and the RSA decryption core. It consumes the receiver's byte stream (`fullout` / `uartFlag` pulses) and parses framed commands. It assembles multi-byte operands (ciphertext, private exponent, modulus) into atomically-committed registers, then sequences the core with a start/done handshake. It also detects malformed frames, inter-byte timeouts and bytes arriving while the core is busy.

## Interface
- `DATA_W`, 32: operand width in bits; must be a multiple of 8, at least 8.
- `TIMEOUT_CLKS`, 3480: maximum idle clocks allowed between bytes inside a frame (4 byte-times at 87 clks/bit).

Ports:
- `i_Clock`  in  1  system clock; all state changes on its rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Rx_Byte`  in  8  received byte from `uart_rx`; valid only when `i_Rx_Valid` is high.
- `i_Rx_Valid`  in  1  one-cycle pulse per received byte.
- `i_Done`  in  1  RSA core completion pulse.
- `o_Cipher`  out  `DATA_W`  ciphertext operand.
- `o_Exp`  out  `DATA_W`  private exponent d.
- `o_Mod`  out  `DATA_W`  modulus n.
- `o_Loaded`  out  3  sticky flags {mod, exp, cipher}; set on each committed load.
- `o_Start`  out  1  one-cycle start pulse to the core.
- `o_Busy`  out  1  high from the `o_Start` cycle until `i_Done` is accepted.
- `o_Err`  out  1  sticky error flag.

## Operation
- Frame format: header 0xA5, then a command byte, then an optional payload.
  - 0x01: load cipher, `DATA_W/8` payload bytes, LSB first.
  - 0x02: load exponent, same payload format.
  - 0x03: load modulus, same payload format.
  - 0x10: start, no payload.
- States: IDLE, CMD, DATA, START, WAIT_DONE.
- IDLE:
  - Valid 0xA5 goes to CMD and clears `o_Err`.
  - Any other byte is ignored silently.
- CMD:
  - 0x01/0x02/0x03: latch the target, clear the byte count, go to DATA.
  - 0x10 with `o_Loaded`==3'b111: go to START.
  - 0x10 with any operand missing: set `o_Err`, go to IDLE.
  - Any other value: set `o_Err`, go to IDLE.
- DATA:
  - Each valid byte is written to `shadow[8*count +: 8]`, then count increments.
  - On byte number `DATA_W/8-1`, shadow plus the final byte are committed to the target register in one edge.
  - The same edge sets the matching `o_Loaded` bit and returns to IDLE.
  - Output registers never show partial frames.
- START: `o_Start`=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE:
  - `i_Done` goes to IDLE.
  - Any valid byte is discarded and sets `o_Err` (overrun); the state is unchanged.
- Timeout:
  - Applies in CMD and DATA only.
  - The counter clears on entry and on each valid byte, and increments otherwise.
  - Reaching `TIMEOUT_CLKS-1` sets `o_Err`, discards the shadow and goes to IDLE.
- Loading does not clear `o_Loaded`; only reset does.
- A reload of an operand overwrites it. This is legal in IDLE only, never while busy.

## Timing
- Reset, asynchronous:
  - State goes to IDLE.
  - `o_Cipher`/`o_Exp`/`o_Mod`=0, `o_Loaded`=3'b000.
  - `o_Start`=0, `o_Busy`=0, `o_Err`=0; counters 0.
  - Reset mid-frame or mid-WAIT_DONE discards everything.
- A byte is accepted at the rising edge where `i_Rx_Valid`=1. The resulting state and outputs are visible the following cycle.
- Final payload byte accepted at edge N: the register, `o_Loaded` bit, and IDLE are all visible at N+1.
- 0x10 accepted at edge N: `o_Start`=1 and `o_Busy`=1 during cycle N+1. `o_Start`=0 from N+2.
- `i_Done` is sampled only in WAIT_DONE. A pulse coincident with the `o_Start` cycle is ignored.
  - Done accepted at edge M: `o_Busy`=0 at M+1.
  - A byte in that same M cycle is still treated as overrun.
- A byte arriving on the same edge the timeout fires: the timeout takes precedence, and the byte is dropped.
- Back-to-back frames are legal: a header on the cycle right after returning to IDLE is accepted.

## Test plan
- Reset: assert `i_Reset` mid-DATA → all outputs 0, state IDLE; the subsequent frame A5 01 EF BE AD DE → `o_Cipher`=32'hDEADBEEF, `o_Loaded`=3'b001.
- Premature start: after reset send A5 10 → `o_Err`=1, `o_Start` never pulses, `o_Busy`=0; then A5 → `o_Err`=0.
- Full sequence:
  - Stimulus: load cipher 0x0000_0BB8, exp 0x0000_0007, mod 0x0000_0D0F, then A5 10.
  - Expect exactly one `o_Start` cycle, and `o_Busy` high until `i_Done` is pulsed.
  - Expect `o_Busy` low the cycle after `i_Done`.
- Overrun: during WAIT_DONE send A5 01 11 22 33 44 → `o_Err`=1, `o_Cipher` unchanged, state stays WAIT_DONE until `i_Done`.
- Timeout: A5 02 11 22, then no bytes for 3480 clocks → `o_Err`=1, `o_Exp` unchanged, IDLE. Next A5 02 01 00 00 00 → `o_Exp`=1.
- Bad command: A5 7F → `o_Err`=1, IDLE.
- Stray bytes in IDLE: 0x00 and 0xFF sent in IDLE → ignored, no error.
- UART path: drive the full A5 03 frame through `uart_rx` at 87 clks/bit → `o_Mod` matches the payload.
